// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and constants for the pipeline sequencing controller:
//   - mws_state_e      : memory-wait FSM state (RUN, MEM_WAIT)
//   - REG_IDX_W        : architectural register index width
//   - MEM_TIMEOUT_DEF  : default watchdog limit, in stall cycles
//   - reg_match()      : "this ID source operand reads register rd" test
package pipe_ctrl_pkg;

    localparam int REG_IDX_W       = 5;
    localparam int MEM_TIMEOUT_DEF = 16;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mws_state_e;

    // True when a source operand is actually read and names register rd.
    function automatic logic reg_match(input logic                 used,
                                       input logic [REG_IDX_W-1:0] rs,
                                       input logic [REG_IDX_W-1:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm
// Tracks outstanding data-memory accesses that did not complete in their
// first cycle, and releases the pipeline either on dmem_ready or when the
// watchdog limit is reached.
//
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   mem_access_ma    : MA instruction is a load/store
//   dmem_ready       : data memory completes the access this cycle
//   dmem_req         : request to data memory (0 while in reset)
//   mem_timeout      : one-cycle pulse on a watchdog (not ready) release
//   wait_release     : MEM_WAIT ends this cycle (ready or watchdog)
//   state_dbg        : current FSM state, also used by the top-level mux
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mem_access_ma,
    input  logic       dmem_ready,
    output logic       dmem_req,
    output logic       mem_timeout,
    output logic       wait_release,
    output mws_state_e state_dbg
);

    localparam int              CNT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    mws_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_at_limit;

    // The detecting RUN cycle plus MEM_WAIT cycles with counter
    // 0..MEM_TIMEOUT-2 are stalls; counter == MEM_TIMEOUT-1 is the forced
    // release, giving MEM_TIMEOUT stall cycles in the worst case.
    assign cnt_at_limit = (cnt_q == CNT_LAST);
    assign wait_release = (state_q == MEM_WAIT) && (dmem_ready || cnt_at_limit);
    assign state_dbg    = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; release always clears the counter, so it never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mem_access_ma && !dmem_ready) begin
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                end
            end
            MEM_WAIT: begin
                if (wait_release) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs; reset abandons any access immediately
    always_comb begin
        dmem_req    = 1'b0;
        mem_timeout = 1'b0;
        if (reset_n) begin
            dmem_req    = (state_q == MEM_WAIT) || mem_access_ma;
            mem_timeout = (state_q == MEM_WAIT) && !dmem_ready && cnt_at_limit;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Pipeline sequencing controller for the five-stage RV32I core. Handles the
// hazards the EX forwarding unit cannot: load-use stalls, taken-branch
// flushes and multi-cycle data-memory waits (with watchdog).
//
// Priority: memory stall > branch flush > load-use > run.
//
// Ports:
//   clk, reset_n                      : clock, synchronous active-low reset
//   rs1_id, rs2_id, rs*_used_id       : source operands of the ID instruction
//   rd_ex, memread_ex                 : destination / load flag of EX instr
//   branch_taken_ex                   : EX resolved a taken branch/jump
//   mem_access_ma, dmem_ready         : MA memory access and completion
//   dmem_req                          : data-memory request
//   pc_en, ifid_en, idex_en,
//   exma_en, mawb_en                  : PC and pipeline-register enables
//   ifid_flush, idex_flush            : load NOP into register on next edge
//   mem_timeout                       : pulse on watchdog release
//   stall_cnt, flush_cnt              : perf counters (PIPE_CTRL_PERF_EN only)
//
// Build option: define PIPE_CTRL_PERF_EN to add the stall_cnt/flush_cnt
// performance counters. Control behaviour is identical either way.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [REG_IDX_W-1:0] rs1_id,
    input  logic [REG_IDX_W-1:0] rs2_id,
    input  logic                 rs1_used_id,
    input  logic                 rs2_used_id,
    input  logic [REG_IDX_W-1:0] rd_ex,
    input  logic                 memread_ex,
    input  logic                 branch_taken_ex,
    input  logic                 mem_access_ma,
    input  logic                 dmem_ready,
    output logic                 dmem_req,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exma_en,
    output logic                 mawb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 mem_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    mws_state_e fsm_state;
    logic       wait_release;
    logic       load_use;
    logic       mem_stall;
    logic       branch_flush;

    mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_access_ma(mem_access_ma),
        .dmem_ready   (dmem_ready),
        .dmem_req     (dmem_req),
        .mem_timeout  (mem_timeout),
        .wait_release (wait_release),
        .state_dbg    (fsm_state)
    );

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = memread_ex && (rd_ex != '0) &&
                      (reg_match(rs1_used_id, rs1_id, rd_ex) ||
                       reg_match(rs2_used_id, rs2_id, rd_ex));

    // RUN stalls on a miss-in-first-cycle; MEM_WAIT stalls until release.
    // The release cycle is not a stall, so branch and load-use still apply.
    assign mem_stall = (fsm_state == RUN) ? (mem_access_ma && !dmem_ready)
                                          : !wait_release;

    assign branch_flush = reset_n && !mem_stall && branch_taken_ex;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exma_en    = 1'b1;
        mawb_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!reset_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exma_en    = 1'b0;
            mawb_en    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_stall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            exma_en = 1'b0;
            mawb_en = 1'b0;
        end else if (branch_taken_ex) begin
            // ID holds a wrong-path instruction, so any load-use is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, inject one bubble into EX.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (branch_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`else
    // Without the perf counters the flush indication has no consumer.
    logic unused_branch_flush;
    assign unused_branch_flush = branch_flush;
`endif

endmodule
